d_seq_packer: RTL

D_SEQ_PACKER -- requirements
Module: d_seq_packer

---
 rtl/d_seq_packer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/d_seq_packer.sv
// Packs D_W-bit items into PACK_N-slot words, first item at the LSBs, with flush for partial words.
// Optional pk_parity output is enabled by defining D_SEQ_PACKER_PARITY_EN.
module d_seq_packer #(
    parameter int PACK_N = 10,
    parameter int D_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [D_W-1:0]        d_data,
    input  logic                  d_flush,
    output logic                  pk_valid,
    input  logic                  pk_ready,
    output logic [PACK_N*D_W-1:0] pk_data,
    output logic [3:0]            pk_count,
    output logic [15:0]           pk_words,
`ifdef D_SEQ_PACKER_PARITY_EN
    output logic                  pk_parity,
`endif
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        IDLE = 4'h0,
        FILL = 4'h1,
        HOLD = 4'h2
    } state_t;

    localparam logic [3:0] PACK_N_W = 4'(PACK_N);

    state_t                  state_q;
    state_t                  state_next;
    logic [3:0]              count_q;
    logic [3:0]              count_next;
    logic [PACK_N*D_W-1:0]   buffer_q;
    logic [PACK_N*D_W-1:0]   buffer_next;
    logic                    accept;
    logic                    deliver;

    assign accept  = d_valid && d_ready;
    assign deliver = pk_valid && pk_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state_q)
            IDLE: begin
                state_next = IDLE;
                if (accept) begin
                    state_next = (PACK_N == 1 || d_flush) ? HOLD : FILL;
                end
            end
            FILL: begin
                state_next = FILL;
                if (accept) begin
                    if ((count_q + 4'd1) == PACK_N_W || d_flush) begin
                        state_next = HOLD;
                    end
                end else if (d_flush) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                state_next = deliver ? IDLE : HOLD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        d_ready  = (state_q == IDLE) || (state_q == FILL);
        pk_valid = (state_q == HOLD);
    end

    // The buffer and count only change on an accept (write slot count) or a delivery (clear).
    always_comb begin
        buffer_next = buffer_q;
        count_next  = count_q;
        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    for (int i = 0; i < PACK_N; i++) begin
                        if (i == int'(count_q)) begin
                            buffer_next[i*D_W +: D_W] = d_data;
                        end
                    end
                    count_next = count_q + 4'd1;
                end
            end
            HOLD: begin
                if (deliver) begin
                    buffer_next = '0;
                    count_next  = '0;
                end
            end
            default: begin
                buffer_next = '0;
                count_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buffer_q <= '0;
            count_q  <= '0;
        end else begin
            buffer_q <= buffer_next;
            count_q  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pk_words <= '0;
        end else if (deliver && pk_words != 16'hFFFF) begin
            pk_words <= pk_words + 16'd1;
        end
    end

`ifdef D_SEQ_PACKER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^buffer_next;
        end
    end

    assign pk_parity = parity_q;
`endif

    assign pk_data  = buffer_q;
    assign pk_count = count_q;
    assign state    = state_q;

endmodule
